// File: rtl/bf_pkg.sv
// Shared definitions for the BF program loader and interpreter:
// opcode encodings, loader state encoding, error codes and word-packing helpers.
package bf_pkg;

   // 4-bit opcode encodings
   localparam logic [3:0] OP_PTR_INC  = 4'b0000;  // '>'
   localparam logic [3:0] OP_PTR_DEC  = 4'b0001;  // '<'
   localparam logic [3:0] OP_INC      = 4'b0010;  // '+'
   localparam logic [3:0] OP_DEC      = 4'b0011;  // '-'
   localparam logic [3:0] OP_OUT      = 4'b0100;  // '.'
   localparam logic [3:0] OP_IN       = 4'b0101;  // ','
   localparam logic [3:0] OP_LOOP_BEG = 4'b0110;  // '['
   localparam logic [3:0] OP_LOOP_END = 4'b0111;  // ']'
   localparam logic [3:0] OP_HALT     = 4'b1111;  // appended terminator / padding

   // Loader session states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_FLUSH = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } bf_ld_state_e;

   // Abort reasons reported on err_code
   localparam logic [1:0] ERR_NONE      = 2'b00;
   localparam logic [1:0] ERR_UNMATCHED = 2'b01;  // ']' with no open '['
   localparam logic [1:0] ERR_UNCLOSED  = 2'b10;  // '[' still open at terminator
   localparam logic [1:0] ERR_OVERFLOW  = 2'b11;  // code memory full

   // Place an opcode into a word slot; slot 0 is the most significant nibble.
   function automatic logic [15:0] put_slot(input logic [15:0] word,
                                            input logic [1:0]  slot,
                                            input logic [3:0]  op);
      logic [15:0] w;
      w = word;
      case (slot)
         2'd0:    w[15:12] = op;
         2'd1:    w[11:8]  = op;
         2'd2:    w[7:4]   = op;
         default: w[3:0]   = op;
      endcase
      return w;
   endfunction

   // Halt in the given slot and pad every later slot with halt.
   function automatic logic [15:0] halt_fill(input logic [15:0] word,
                                             input logic [1:0]  slot);
      logic [15:0] w;
      case (slot)
         2'd0:    w = 16'hFFFF;
         2'd1:    w = {word[15:12], 12'hFFF};
         2'd2:    w = {word[15:8], 8'hFF};
         default: w = {word[15:4], 4'hF};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/bf_ascii_decode.sv
// Combinational ASCII-to-opcode decoder. Non-command bytes are reported as
// neither opcode nor terminator so the loader can drop them as comments.
module bf_ascii_decode
   import bf_pkg::*;
(
   input  logic [7:0] i_char,
   output logic [3:0] o_opcode,
   output logic       o_is_op,
   output logic       o_is_term
);

   // Map one source character to its opcode class
   always_comb begin
      o_opcode  = OP_HALT;
      o_is_op   = 1'b0;
      o_is_term = 1'b0;
      case (i_char)
         8'h3E: begin o_opcode = OP_PTR_INC;  o_is_op = 1'b1; end
         8'h3C: begin o_opcode = OP_PTR_DEC;  o_is_op = 1'b1; end
         8'h2B: begin o_opcode = OP_INC;      o_is_op = 1'b1; end
         8'h2D: begin o_opcode = OP_DEC;      o_is_op = 1'b1; end
         8'h2E: begin o_opcode = OP_OUT;      o_is_op = 1'b1; end
         8'h2C: begin o_opcode = OP_IN;       o_is_op = 1'b1; end
         8'h5B: begin o_opcode = OP_LOOP_BEG; o_is_op = 1'b1; end
         8'h5D: begin o_opcode = OP_LOOP_END; o_is_op = 1'b1; end
         8'h00: begin o_opcode = OP_HALT;     o_is_term = 1'b1; end
         8'h21: begin o_opcode = OP_HALT;     o_is_term = 1'b1; end
         default: begin
            o_opcode  = OP_HALT;
            o_is_op   = 1'b0;
            o_is_term = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/bf_program_loader.sv
// Streams ASCII BF source into code memory as packed 4-opcode words,
// checking bracket balance and memory capacity along the way.
module bf_program_loader
   import bf_pkg::*;
#(
   parameter int N = 8
)
(
   input  logic         clock,
   input  logic         reset_n,
   input  logic         start,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic         wr_en,
   output logic [N-3:0] wr_addr,
   output logic [15:0]  wr_data,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [1:0]   err_code,
   output logic [N-1:0] length
);

   localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-3:0] ONE_A  = {{(N-3){1'b0}}, 1'b1};
   localparam logic [N-1:0] FULL_N = {N{1'b1}};

   bf_ld_state_e  r_state;
   logic          r_in_ready;
   logic          r_busy;
   logic          r_wr_en;
   logic [N-3:0]  r_addr;
   logic [15:0]   r_wr_data;
   logic [15:0]   r_buf;
   logic [N-1:0]  r_len;
   logic          r_full;     // all 2**N slots hold opcodes
   logic [N-1:0]  r_depth;
   logic          r_done;
   logic          r_error;
   logic [1:0]    r_err_code;

   logic [3:0]    w_opcode;
   logic          w_is_op;
   logic          w_is_term;
   logic          w_accept;
   logic [1:0]    w_slot;
   logic [15:0]   w_put;

   bf_ascii_decode u_decode (
      .i_char    (in_data),
      .o_opcode  (w_opcode),
      .o_is_op   (w_is_op),
      .o_is_term (w_is_term)
   );

   // Slot position follows directly from the opcode count
   assign w_accept = in_valid & r_in_ready;
   assign w_slot   = r_len[1:0];
   assign w_put    = put_slot(r_buf, w_slot, w_opcode);

   // Session FSM; every output is registered here
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_wr_en    <= 1'b0;
         r_addr     <= '0;
         r_wr_data  <= 16'h0000;
         r_buf      <= 16'h0000;
         r_len      <= '0;
         r_full     <= 1'b0;
         r_depth    <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_wr_en <= 1'b0;
         // A word written last cycle advances the address
         if (r_wr_en) begin
            r_addr <= r_addr + ONE_A;
         end
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (start) begin
                  r_state    <= ST_LOAD;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_addr     <= '0;
                  r_buf      <= 16'h0000;
                  r_len      <= '0;
                  r_full     <= 1'b0;
                  r_depth    <= '0;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
                  r_err_code <= ERR_NONE;
               end
            end
            ST_LOAD: begin
               if (w_accept && (w_is_op || w_is_term)) begin
                  if (r_full) begin
                     // No slot left for an opcode or the halt
                     r_state    <= ST_ERROR;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                     r_err_code <= ERR_OVERFLOW;
                  end else if (w_is_term) begin
                     r_buf      <= halt_fill(r_buf, w_slot);
                     r_state    <= ST_FLUSH;
                     r_in_ready <= 1'b0;
                  end else if ((w_opcode == OP_LOOP_END) && (r_depth == '0)) begin
                     r_state    <= ST_ERROR;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                     r_err_code <= ERR_UNMATCHED;
                  end else begin
                     r_buf <= w_put;
                     // Length saturates; the last slot is tracked by r_full
                     if (r_len == FULL_N) begin
                        r_full <= 1'b1;
                     end else begin
                        r_len <= r_len + ONE_N;
                     end
                     if (w_opcode == OP_LOOP_BEG) begin
                        r_depth <= r_depth + ONE_N;
                     end else if (w_opcode == OP_LOOP_END) begin
                        r_depth <= r_depth - ONE_N;
                     end
                     if (w_slot == 2'd3) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= w_put;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               // Final (halt-padded) word goes out exactly once
               r_wr_en   <= 1'b1;
               r_wr_data <= r_buf;
               r_busy    <= 1'b0;
               if (r_depth == '0) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state    <= ST_ERROR;
                  r_error    <= 1'b1;
                  r_err_code <= ERR_UNCLOSED;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = r_in_ready;
   assign wr_en    = r_wr_en;
   assign wr_addr  = r_addr;
   assign wr_data  = r_wr_data;
   assign busy     = r_busy;
   assign done     = r_done;
   assign error    = r_error;
   assign err_code = r_err_code;
   assign length   = r_len;

endmodule

// File: tb/tb_bf_program_loader.sv
// Directed bench for bf_program_loader: expected code-memory writes are
// queued as stimulus is driven and checked by a write monitor.
module tb_bf_program_loader;

   localparam int N = 8;

   logic         clock;
   logic         reset_n;
   logic         start;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         wr_en;
   logic [N-3:0] wr_addr;
   logic [15:0]  wr_data;
   logic         busy;
   logic         done;
   logic         error;
   logic [1:0]   err_code;
   logic [N-1:0] length;

   int checks   = 0;
   int failures = 0;
   logic [N-3+16:0] exp_q[$];

   bf_program_loader #(.N(N)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .err_code (err_code),
      .length   (length)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Write monitor: every strobe must match the head of the scoreboard
   always @(negedge clock) begin
      logic [N-3+16:0] e;
      if (reset_n === 1'b1 && wr_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL unexpected_write observed=%0h@%0d expected=none", wr_data, wr_addr);
         end else begin
            e = exp_q.pop_front();
            assert ({wr_addr, wr_data} === e) else begin
               failures++;
               $error("FAIL write observed=%0h@%0d expected=%0h@%0d",
                      wr_data, wr_addr, e[15:0], e[N-3+16:16]);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_wr(input int addr, input logic [15:0] data);
      logic [N-3:0] a;
      a = addr[N-3:0];
      exp_q.push_back({a, data});
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (in_ready !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      if (in_ready !== 1'b1) begin
         check("send_timeout", {31'd0, in_ready}, 32'd1);
      end else begin
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 50) begin
         step();
         n++;
      end
      check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
      step();
      check({tag, "_writes_drained"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      #12;
      check("rst_busy",    {31'd0, busy},     32'd0);
      check("rst_ready",   {31'd0, in_ready}, 32'd0);
      check("rst_done",    {31'd0, done},     32'd0);
      check("rst_error",   {31'd0, error},    32'd0);
      check("rst_length",  {24'd0, length},   32'd0);
      check("rst_wr_addr", {26'd0, wr_addr},  32'd0);
      reset_n = 1'b1;
      step();
      check("idle_ready", {31'd0, in_ready}, 32'd0);

      // "+[-]" NUL
      do_start();
      check("a_busy",  {31'd0, busy},     32'd1);
      check("a_ready", {31'd0, in_ready}, 32'd1);
      push_wr(0, 16'h2637);
      push_wr(1, 16'hFFFF);
      send_str("+[-]");
      send_byte(8'h00);
      wait_idle("a");
      check("a_done",   {31'd0, done},     32'd1);
      check("a_error",  {31'd0, error},    32'd0);
      check("a_length", {24'd0, length},   32'd4);
      check("a_code",   {30'd0, err_code}, 32'd0);

      // "a+ b." '!' with a start pulse mid-session that must be ignored
      do_start();
      push_wr(0, 16'h24FF);
      send_str("a+");
      do_start();
      send_str(" b.");
      send_byte(8'h21);
      wait_idle("b");
      check("b_done",   {31'd0, done},   32'd1);
      check("b_length", {24'd0, length}, 32'd2);

      // "+]" unmatched close
      do_start();
      send_str("+]");
      check("c_error", {31'd0, error},    32'd1);
      check("c_code",  {30'd0, err_code}, 32'd1);
      check("c_ready", {31'd0, in_ready}, 32'd0);
      check("c_done",  {31'd0, done},     32'd0);
      wait_idle("c");

      // "[[" NUL unclosed
      do_start();
      push_wr(0, 16'h66FF);
      send_str("[[");
      send_byte(8'h00);
      wait_idle("d");
      check("d_error", {31'd0, error},    32'd1);
      check("d_code",  {30'd0, err_code}, 32'd2);
      check("d_done",  {31'd0, done},     32'd0);

      // 255 '+' then NUL fills memory exactly
      do_start();
      for (int i = 0; i < 63; i++) push_wr(i, 16'h2222);
      push_wr(63, 16'h222F);
      for (int i = 0; i < 255; i++) send_byte(8'h2B);
      send_byte(8'h00);
      wait_idle("e");
      check("e_done",   {31'd0, done},   32'd1);
      check("e_error",  {31'd0, error},  32'd0);
      check("e_length", {24'd0, length}, 32'd255);

      // 256 '+' then NUL overflows
      do_start();
      for (int i = 0; i < 64; i++) push_wr(i, 16'h2222);
      for (int i = 0; i < 256; i++) send_byte(8'h2B);
      send_byte(8'h00);
      check("f_error", {31'd0, error},    32'd1);
      check("f_code",  {30'd0, err_code}, 32'd3);
      check("f_done",  {31'd0, done},     32'd0);
      wait_idle("f");

      // Reset mid-session after 6 opcodes, then reload from address 0
      do_start();
      push_wr(0, 16'h2222);
      for (int i = 0; i < 6; i++) send_byte(8'h2B);
      reset_n = 1'b0;
      #1;
      check("g_busy",     {31'd0, busy},     32'd0);
      check("g_ready",    {31'd0, in_ready}, 32'd0);
      check("g_wr_en",    {31'd0, wr_en},    32'd0);
      check("g_wr_addr",  {26'd0, wr_addr},  32'd0);
      check("g_wr_data",  {16'd0, wr_data},  32'd0);
      check("g_length",   {24'd0, length},   32'd0);
      check("g_code",     {30'd0, err_code}, 32'd0);
      check("g_flags",    {30'd0, done, error}, 32'd0);
      #3;
      reset_n = 1'b1;
      step();
      check("g_idle_ready", {31'd0, in_ready}, 32'd0);
      do_start();
      push_wr(0, 16'h2345);
      push_wr(1, 16'hFFFF);
      send_str("+-.,");
      send_byte(8'h00);
      wait_idle("h");
      check("h_done",   {31'd0, done},   32'd1);
      check("h_length", {24'd0, length}, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
